// File: rtl/seg_pkg.sv
// Shared constants and types for the six-digit seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIG = 6;
  localparam int SEG_W   = 7;
  localparam int FRAME_W = NUM_DIG * SEG_W;

  localparam logic [SEG_W-1:0]   SEG_BLANK   = 7'b0000000;
  localparam logic [NUM_DIG-1:0] ENB_ALL_OFF = 6'b111111;

  // Digit k occupies seg[k], which lines up with bits [7k+6:7k] of the flat bus.
  typedef struct packed {
    logic [NUM_DIG-1:0][SEG_W-1:0] seg;
    logic [NUM_DIG-1:0]            dp;
  } frame_t;

  // Number of slot cycles the digit stays lit: (bright+1)/8 of the slot.
  function automatic logic [31:0] pwm_thresh(input logic [2:0] bright,
                                             input int unsigned scan_div);
    return (32'(bright) + 32'd1) * (scan_div / 32'd8);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame offer handshake between a frame producer and the scan controller.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic [FRAME_W-1:0] i_frame_seg;
  logic [NUM_DIG-1:0] i_frame_dp;
  logic               i_frame_vld;
  logic               o_frame_rdy;

  modport master (output i_frame_seg, i_frame_dp, i_frame_vld, input o_frame_rdy);
  modport slave  (input i_frame_seg, i_frame_dp, i_frame_vld, output o_frame_rdy);

endinterface

// File: rtl/blink_gen.sv
// Free-running divider: phase_o toggles once every BLINK_DIV clock cycles.
module blink_gen #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase_o
);

  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_o <= 1'b0;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_q   <= '0;
      phase_o <= ~phase_o;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed six-digit seven-segment scanner with PWM brightness and
// double-buffered frames. Define SEG_SCAN_BLINK_EN to enable per-digit blinking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_ctrl_if.slave      frm,
  input  logic [NUM_DIG-1:0]  i_blink_mask,
  input  logic [2:0]          i_bright,
  output logic [SEG_W-1:0]    o_seg,
  output logic                o_seg_dp,
  output logic [NUM_DIG-1:0]  o_seg_enb,
  output logic                o_frame_done
);

  localparam int SLOT_W = $clog2(SCAN_DIV);

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]        dig_idx_q, dig_idx_d;
  frame_t            active_q, active_d;
  frame_t            pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [SEG_W-1:0]  seg_d;
  logic              dp_d;
  logic [NUM_DIG-1:0] enb_d;

  logic slot_wrap, boundary, accept, lit, blink_phase;

`ifdef SEG_SCAN_BLINK_EN
  blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .phase_o (blink_phase)
  );
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^i_blink_mask;
  assign blink_phase       = 1'b0;
`endif

  assign frm.o_frame_rdy = ~pend_full_q;

  always_comb begin
    slot_wrap = (slot_cnt_q == SLOT_W'(SCAN_DIV - 1));
    boundary  = slot_wrap && (dig_idx_q == 3'(NUM_DIG - 1));
    accept    = frm.i_frame_vld && !pend_full_q;

    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    dig_idx_d  = dig_idx_q;
    if (slot_wrap) dig_idx_d = boundary ? 3'd0 : dig_idx_q + 3'd1;

    // Commit and accept are mutually exclusive: commit needs a full buffer,
    // accept needs an empty one, so a boundary-cycle accept waits a full frame.
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (boundary && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d.seg  = frm.i_frame_seg;
      pend_d.dp   = frm.i_frame_dp;
      pend_full_d = 1'b1;
    end

    lit = (32'(slot_cnt_q) < pwm_thresh(i_bright, SCAN_DIV));
`ifdef SEG_SCAN_BLINK_EN
    if (blink_phase && i_blink_mask[dig_idx_q]) lit = 1'b0;
`else
    if (blink_phase) lit = 1'b0;
`endif

    seg_d = lit ? active_q.seg[dig_idx_q] : SEG_BLANK;
    dp_d  = lit ? active_q.dp[dig_idx_q]  : 1'b0;
    enb_d = lit ? ~(NUM_DIG'(1) << dig_idx_q) : ENB_ALL_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      dig_idx_q    <= '0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      o_seg        <= SEG_BLANK;
      o_seg_dp     <= 1'b0;
      o_seg_enb    <= ENB_ALL_OFF;
      o_frame_done <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      dig_idx_q    <= dig_idx_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      o_seg        <= seg_d;
      o_seg_dp     <= dp_d;
      o_seg_enb    <= enb_d;
      o_frame_done <= boundary;
    end
  end

endmodule
